usbdev_aon_suspend_seq: RTL



---
 rtl/usbdev_pkg.sv | 21 ++
 rtl/usbdev_aon_suspend_seq_if.sv | 34 +++
 rtl/usbdev_aon_suspend_seq.sv | 118 +++++++++++
 3 files changed

// File: rtl/usbdev_pkg.sv
// Shared USB device definitions for the AON-domain blocks.
// Holds the suspend sequencer state, wake-cause types and default timeout.
package usbdev_pkg;

    typedef enum logic [2:0] {
        AonIdle    = 3'd0,
        AonArm     = 3'd1,
        AonMonitor = 3'd2,
        AonWake    = 3'd3,
        AonRelease = 3'd4
    } aon_seq_state_e;

    typedef struct packed {
        logic sense_lost;
        logic bus_reset;
        logic not_idle;
    } aon_wake_cause_t;

    localparam int AonSeqTimeoutDefault = 16;

endpackage

// File: rtl/usbdev_aon_suspend_seq_if.sv
// Signal bundle between the AON suspend sequencer and its neighbours:
// the USB IP, the wake detector and the power manager.
interface usbdev_aon_suspend_seq_if;

    logic       suspend_i;
    logic       sw_wake_ack_i;
    logic       wd_active_i;
    logic       wd_wake_req_i;
    logic       wd_not_idle_i;
    logic       wd_bus_reset_i;
    logic       wd_sense_lost_i;
    logic       wd_suspend_req_o;
    logic       wd_wake_ack_o;
    logic       lp_ready_o;
    logic       pwr_wake_req_o;
    logic [2:0] cause_o;
    logic       timeout_o;
    logic [2:0] state_o;

    modport master (
        output suspend_i, sw_wake_ack_i, wd_active_i, wd_wake_req_i,
        output wd_not_idle_i, wd_bus_reset_i, wd_sense_lost_i,
        input  wd_suspend_req_o, wd_wake_ack_o, lp_ready_o,
        input  pwr_wake_req_o, cause_o, timeout_o, state_o
    );

    modport slave (
        input  suspend_i, sw_wake_ack_i, wd_active_i, wd_wake_req_i,
        input  wd_not_idle_i, wd_bus_reset_i, wd_sense_lost_i,
        output wd_suspend_req_o, wd_wake_ack_o, lp_ready_o,
        output pwr_wake_req_o, cause_o, timeout_o, state_o
    );

endinterface

// File: rtl/usbdev_aon_suspend_seq.sv
// AON suspend/wake handshake sequencer in front of the USB wake detector.
// Optional ARM/RELEASE watchdog: define USBDEV_AON_SEQ_TIMEOUT_EN.
module usbdev_aon_suspend_seq
    import usbdev_pkg::*;
#(
    parameter int TimeoutCycles = AonSeqTimeoutDefault
) (
    input logic                      clk_aon_i,
    input logic                      rst_aon_ni,
    usbdev_aon_suspend_seq_if.slave  bus
);

    aon_seq_state_e  state_q, state_d;
    aon_wake_cause_t cause_q, cause_d, evt;
    logic            tmo_fire;

    assign evt = '{sense_lost: bus.wd_sense_lost_i,
                   bus_reset:  bus.wd_bus_reset_i,
                   not_idle:   bus.wd_not_idle_i};

`ifdef USBDEV_AON_SEQ_TIMEOUT_EN
    logic [7:0] cnt_q;
    logic       tmo_q;
    logic       in_hold;
    logic       hold_exit;

    assign in_hold   = (state_q == AonArm) || (state_q == AonRelease);
    assign hold_exit = (state_q == AonArm) ? bus.wd_active_i
                                           : !bus.wd_active_i;
    // A real exit in the expiry cycle beats the watchdog.
    assign tmo_fire  = in_hold && !hold_exit &&
                       (cnt_q == 8'(TimeoutCycles - 1));

    always_ff @(posedge clk_aon_i or negedge rst_aon_ni) begin
        if (!rst_aon_ni) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            tmo_q <= tmo_fire;
            if (state_d != state_q &&
                (state_d == AonArm || state_d == AonRelease)) begin
                cnt_q <= '0;
            end else if (in_hold) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    assign bus.timeout_o = tmo_q;
`else
    logic unused_cfg;

    assign unused_cfg    = ^8'(TimeoutCycles);
    assign tmo_fire      = 1'b0;
    assign bus.timeout_o = 1'b0;
`endif

    always_ff @(posedge clk_aon_i or negedge rst_aon_ni) begin
        if (!rst_aon_ni) begin
            state_q <= AonIdle;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            AonIdle: begin
                if (bus.suspend_i) begin
                    state_d = AonArm;
                    cause_d = '0;
                end
            end
            AonArm: begin
                if (bus.wd_active_i) state_d = AonMonitor;
                else if (tmo_fire)   state_d = AonIdle;
            end
            AonMonitor: begin
                cause_d = aon_wake_cause_t'(cause_q | evt);
                if (bus.sw_wake_ack_i)       state_d = AonRelease;
                else if (!bus.wd_active_i)   state_d = AonIdle;
                else if (bus.wd_wake_req_i)  state_d = AonWake;
            end
            AonWake: begin
                cause_d = aon_wake_cause_t'(cause_q | evt);
                if (bus.sw_wake_ack_i)      state_d = AonRelease;
                else if (!bus.wd_active_i)  state_d = AonIdle;
            end
            AonRelease: begin
                if (!bus.wd_active_i) state_d = AonIdle;
                else if (tmo_fire)    state_d = AonIdle;
            end
            default: state_d = AonIdle;
        endcase
    end

    always_comb begin
        bus.wd_suspend_req_o = 1'b0;
        bus.wd_wake_ack_o    = 1'b0;
        bus.lp_ready_o       = 1'b0;
        bus.pwr_wake_req_o   = 1'b0;
        case (state_q)
            AonArm:     bus.wd_suspend_req_o = 1'b1;
            AonMonitor: bus.lp_ready_o       = 1'b1;
            AonWake:    bus.pwr_wake_req_o   = 1'b1;
            AonRelease: bus.wd_wake_ack_o    = 1'b1;
            default: ;
        endcase
    end

    assign bus.cause_o = cause_q;
    assign bus.state_o = state_q;

endmodule
